// File: rtl/jtframe_rom_pkg.sv
// ---------------------------------------------------------------------------
// jtframe_rom_pkg
// Shared definitions for the ROM channel arbiter:
//   - arb_state_t      : request FSM states (idle / requesting / waiting data)
//   - ARB_FIXED,
//     ARB_ROUND_ROBIN  : values of the arbiter RR parameter
//   - idx_width()      : width of a channel index (never below 1 bit)
// ---------------------------------------------------------------------------
package jtframe_rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED       = 0;
    localparam int ARB_ROUND_ROBIN = 1;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// ---------------------------------------------------------------------------
// jtframe_rr_pick
// Combinational rotating-priority picker. The search starts at the channel
// right after pointer_i and wraps, so the pointer channel itself is the
// lowest priority. Tying pointer_i to CHANNELS-1 yields fixed priority with
// channel 0 highest.
//   pending_i : per-channel request bits
//   pointer_i : index of the most recently served channel
//   grant_o   : index of the selected channel (0 when any_o is low)
//   any_o     : at least one pending bit is set
// ---------------------------------------------------------------------------
module jtframe_rr_pick
    import jtframe_rom_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IW       = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] pending_i,
    input  logic [IW-1:0]       pointer_i,
    output logic [IW-1:0]       grant_o,
    output logic                any_o
);

    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = IW'((int'(pointer_i) + k) % CHANNELS);
            if (!any_o && pending_i[cand]) begin
                grant_o = cand;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// ---------------------------------------------------------------------------
// jtframe_rom_arb
// N-channel arbiter between game ROM readers and the single SDRAM port.
// Each channel keeps a one-entry tagged cache; a channel whose address
// matches its tag is served combinationally, any other active channel
// competes for the SDRAM port. Only one SDRAM request is ever outstanding.
//   clk, rst          : clock, synchronous active-high reset
//   downloading       : ROM download, aborts the FSM and flushes all caches
//   loop_rst          : SDRAM init loop, blocks new grants only
//   ch_cs / ch_addr   : per-channel read enable and packed addresses
//   ch_ok / ch_data   : per-channel hit flag and packed cached data
//   sdram_addr/_req   : outstanding request, req held until sdram_ack
//   sdram_ack         : request accepted (one-cycle pulse)
//   data_read/_rdy    : read data and its one-cycle valid strobe
// ---------------------------------------------------------------------------
module jtframe_rom_arb
    import jtframe_rom_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int AW       = 22,
    parameter int DW       = 32,
    parameter int RR       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   downloading,
    input  logic                   loop_rst,
    input  logic [CHANNELS-1:0]    ch_cs,
    input  logic [CHANNELS*AW-1:0] ch_addr,
    output logic [CHANNELS-1:0]    ch_ok,
    output logic [CHANNELS*DW-1:0] ch_data,
    output logic [AW-1:0]          sdram_addr,
    output logic                   sdram_req,
    input  logic                   sdram_ack,
    input  logic [DW-1:0]          data_read,
    input  logic                   data_rdy
);

    localparam int            IW      = idx_width(CHANNELS);
    localparam logic [IW-1:0] LAST_CH = IW'(CHANNELS - 1);
    localparam bit            USE_RR  = (RR == ARB_ROUND_ROBIN);

    arb_state_t         state_q;
    logic [IW-1:0]      gnt_q;
    logic [IW-1:0]      ptr_q;
    logic [AW-1:0]      addr_q;
    logic               req_q;
    logic [CHANNELS-1:0] valid_q;
    logic [AW-1:0]      tag_q  [CHANNELS];
    logic [DW-1:0]      data_q [CHANNELS];

    logic [AW-1:0]      addr_a [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] pending;
    logic [IW-1:0]      pick_ptr;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               fill_en;

    // Hit uses the live address against the registered tag, so a hit is
    // visible in the same cycle the address is presented.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign addr_a[i]            = ch_addr[i*AW +: AW];
        assign hit[i]               = ch_cs[i] & valid_q[i] & (tag_q[i] == addr_a[i]);
        assign ch_data[i*DW +: DW]  = data_q[i];
    end

    assign ch_ok      = hit;
    assign pending    = ch_cs & ~hit;
    assign pick_ptr   = USE_RR ? ptr_q : LAST_CH;
    assign sdram_addr = addr_q;
    assign sdram_req  = req_q;
    assign fill_en    = (state_q == ST_WAIT) && data_rdy && !downloading;

    jtframe_rr_pick #(
        .CHANNELS (CHANNELS),
        .IW       (IW)
    ) u_pick (
        .pending_i (pending),
        .pointer_i (pick_ptr),
        .grant_o   (pick_idx),
        .any_o     (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= LAST_CH;
            addr_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= '0;
            for (int i = 0; i < CHANNELS; i++) data_q[i] <= '0;
        end else if (downloading) begin
            // Abort whatever is in flight; a late data_rdy finds us in IDLE.
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any && !loop_rst) begin
                        gnt_q   <= pick_idx;
                        addr_q  <= addr_a[pick_idx];
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The fill uses the address latched at grant time, so a
                    // channel that moved on meanwhile just misses again.
                    if (data_rdy) begin
                        data_q[gnt_q]  <= data_read;
                        valid_q[gnt_q] <= 1'b1;
                        ptr_q          <= gnt_q;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: tags carry no reset; a tag is only ever compared while its valid
    // bit is set, and valid bits are cleared by reset and download.
    always_ff @(posedge clk) begin
        if (fill_en) tag_q[gnt_q] <= addr_q;
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// ---------------------------------------------------------------------------
// tb_jtframe_rom_arb
// Self-checking bench for jtframe_rom_arb (4 channels, 22-bit addresses,
// 32-bit data). A round-robin instance is the main target; a fixed-priority
// instance shares its inputs to contrast grant order. Directed sequences
// cover reset, miss/hit, grant order, download abort, stale fill, loop_rst
// and a hit table; a random phase compares against a transaction model.
// ---------------------------------------------------------------------------
module tb_jtframe_rom_arb;
    import jtframe_rom_pkg::*;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst, downloading, loop_rst;
    logic [N-1:0]    ch_cs;
    logic [N*AW-1:0] ch_addr;
    logic [N-1:0]    ch_ok,   fp_ok;
    logic [N*DW-1:0] ch_data, fp_data;
    logic [AW-1:0]   sdram_addr, fp_addr;
    logic            sdram_req,  fp_req;
    logic            sdram_ack, data_rdy;
    logic [DW-1:0]   data_read;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtframe_rom_arb #(.CHANNELS(N), .AW(AW), .DW(DW), .RR(ARB_ROUND_ROBIN)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
        .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_ok(ch_ok), .ch_data(ch_data),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .data_read(data_read), .data_rdy(data_rdy)
    );

    jtframe_rom_arb #(.CHANNELS(N), .AW(AW), .DW(DW), .RR(ARB_FIXED)) dut_fp (
        .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
        .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_ok(fp_ok), .ch_data(fp_data),
        .sdram_addr(fp_addr), .sdram_req(fp_req), .sdram_ack(sdram_ack),
        .data_read(data_read), .data_rdy(data_rdy)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        ch_addr[c*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] dat(input int c);
        return ch_data[c*DW +: DW];
    endfunction

    task automatic do_reset();
        rst = 1'b1; ch_cs = '0; downloading = 1'b0; loop_rst = 1'b0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for a request, then check the address it carries.
    task automatic wait_req(input string name, input logic [AW-1:0] exp_addr);
        int t = 0;
        while (!sdram_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, " req"}, 128'(sdram_req), 128'(1));
        check({name, " addr"}, 128'(sdram_addr), 128'(exp_addr));
    endtask

    task automatic pulse_ack();
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    task automatic pulse_rdy(input logic [DW-1:0] d);
        data_read = d;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
    endtask

    task automatic serve(input string name, input logic [AW-1:0] exp_rr,
                         input bit chk_fp, input logic [AW-1:0] exp_fp,
                         input int ack_wait, input int rdy_wait, input logic [DW-1:0] d);
        wait_req(name, exp_rr);
        if (chk_fp) check({name, " fp addr"}, 128'(fp_addr), 128'(exp_fp));
        repeat (ack_wait) @(negedge clk);
        pulse_ack();
        check({name, " req drop"}, 128'(sdram_req), 128'(0));
        repeat (rdy_wait) @(negedge clk);
        pulse_rdy(d);
    endtask

    // --------------------------------------------------------- reference model
    // Cache contents per channel plus a queue holding the single outstanding
    // SDRAM transaction. Updated once per clock edge from the inputs seen
    // just before that edge.
    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        bit            acked;
    } xfer_t;

    bit            m_valid [N];
    logic [AW-1:0] m_tag   [N];
    logic [DW-1:0] m_data  [N];
    logic [AW-1:0] m_addr;
    int            m_ptr;
    xfer_t         q_out [$];

    function automatic logic [N-1:0] m_hit();
        logic [N-1:0] h;
        for (int c = 0; c < N; c++)
            h[c] = ch_cs[c] && m_valid[c] && (m_tag[c] == ch_addr[c*AW +: AW]);
        return h;
    endfunction

    function automatic int rr_choose(input logic [N-1:0] pend, input int ptr);
        for (int k = 1; k <= N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_valid[c] = 1'b0;
            m_tag[c]   = '0;
            m_data[c]  = '0;
        end
        m_addr = '0;
        m_ptr  = N - 1;
        q_out.delete();
    endtask

    task automatic model_edge();
        logic [N-1:0] pend;
        xfer_t        x;
        int           g;
        pend = ch_cs & ~m_hit();
        if (downloading) begin
            q_out.delete();
            for (int c = 0; c < N; c++) m_valid[c] = 1'b0;
        end else if (q_out.size() == 0) begin
            if (pend != 0 && !loop_rst) begin
                g      = rr_choose(pend, m_ptr);
                x.ch   = g;
                x.addr = ch_addr[g*AW +: AW];
                x.acked = 1'b0;
                q_out.push_back(x);
                m_addr = x.addr;
            end
        end else if (!q_out[0].acked) begin
            if (sdram_ack) begin
                x = q_out[0];
                x.acked = 1'b1;
                q_out[0] = x;
            end
        end else if (data_rdy) begin
            x = q_out.pop_front();
            m_data[x.ch]  = data_read;
            m_tag[x.ch]   = x.addr;
            m_valid[x.ch] = 1'b1;
            m_ptr         = x.ch;
        end
    endtask

    // ------------------------------------------------------------ hit table
    typedef struct {
        logic [N-1:0]    cs;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    ok;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [N*AW-1:0] all_tags;
        logic [N*DW-1:0] exp_data;

        all_tags = {22'h0D0, 22'h0C0, 22'h0B0, 22'h0A0};
        vecs[0] = '{4'hF, all_tags, 4'hF};
        vecs[1] = '{4'h0, all_tags, 4'h0};
        vecs[2] = '{4'h5, all_tags, 4'h5};
        vecs[3] = '{4'hF, {22'h0D0, 22'h0C0, 22'h0B1, 22'h0A0}, 4'hD};
        vecs[4] = '{4'hA, {22'h0D3, 22'h0C0, 22'h0B0, 22'h0A0}, 4'h2};
        vecs[5] = '{4'hF, {22'h0D1, 22'h0C1, 22'h0B1, 22'h0A1}, 4'h0};
        vecs[6] = '{4'h1, {22'h0D0, 22'h0C0, 22'h0B0, 22'h0B0}, 4'h0};
        vecs[7] = '{4'h8, all_tags, 4'h8};
        vecs[8] = '{4'hF, {22'h0A0, 22'h0B0, 22'h0C0, 22'h0D0}, 4'h0};

        // ---- reset with every channel requesting
        rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        ch_cs = 4'hF;
        for (int c = 0; c < N; c++) set_addr(c, 22'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset ok",   128'(ch_ok),      128'(0));
            check("reset req",  128'(sdram_req),  128'(0));
            check("reset addr", 128'(sdram_addr), 128'(0));
        end
        rst = 1'b0; ch_cs = '0;
        #1;
        check("reset data", 128'(ch_data), 128'(0));
        check("reset ok after", 128'(ch_ok), 128'(0));
        @(negedge clk);
        check("idle no req", 128'(sdram_req), 128'(0));

        // ---- miss then hit on channel 1
        ch_cs = 4'b0010;
        set_addr(1, 22'h01234);
        serve("miss1", 22'h01234, 1'b1, 22'h01234, 1, 2, 32'hDEADBEEF);
        check("hit1 ok",   128'(ch_ok[1]), 128'(1));
        check("hit1 data", 128'(dat(1)),   128'(32'hDEADBEEF));
        set_addr(1, 22'h01235);
        #1;
        check("addr change ok", 128'(ch_ok[1]), 128'(0));
        serve("miss1b", 22'h01235, 1'b0, '0, 0, 0, 32'h0BADF00D);
        check("hit1b ok",   128'(ch_ok[1]), 128'(1));
        check("hit1b data", 128'(dat(1)),   128'(32'h0BADF00D));

        // ---- grant order, round-robin vs fixed priority
        do_reset();
        set_addr(0, 22'h100); set_addr(1, 22'h200);
        set_addr(2, 22'h300); set_addr(3, 22'h400);
        ch_cs = 4'hF;
        serve("rr g0", 22'h100, 1'b1, 22'h100, 0, 0, 32'hA0A0A0A0);
        check("latency ok0", 128'(ch_ok[0]), 128'(1));
        serve("rr g1", 22'h200, 1'b1, 22'h200, 0, 1, 32'hA1A1A1A1);
        serve("rr g2", 22'h300, 1'b1, 22'h300, 1, 0, 32'hA2A2A2A2);
        serve("rr g3", 22'h400, 1'b1, 22'h400, 0, 0, 32'hA3A3A3A3);
        check("rr all ok", 128'(ch_ok), 128'(4'hF));
        set_addr(1, 22'h210);
        serve("rr ptr->1", 22'h210, 1'b1, 22'h210, 0, 0, 32'hB1B1B1B1);
        set_addr(0, 22'h110); set_addr(2, 22'h310);
        serve("rr 2 before 0", 22'h310, 1'b1, 22'h110, 0, 0, 32'hB2B2B2B2);
        serve("rr then 0",     22'h110, 1'b1, 22'h310, 0, 0, 32'hB0B0B0B0);
        check("rr final ok", 128'(ch_ok), 128'(4'hF));
        check("fp final ok", 128'(fp_ok), 128'(4'hF));

        // ---- downloading while waiting for channel 2 data
        do_reset();
        ch_cs = 4'b0001;
        set_addr(0, 22'h050);
        serve("dl pre", 22'h050, 1'b0, '0, 0, 0, 32'h11111111);
        check("dl pre ok", 128'(ch_ok[0]), 128'(1));
        set_addr(2, 22'h500);
        ch_cs = 4'b0101;
        wait_req("dl req", 22'h500);
        pulse_ack();
        downloading = 1'b1;
        @(negedge clk);
        check("dl ok",  128'(ch_ok),     128'(0));
        check("dl req", 128'(sdram_req), 128'(0));
        pulse_rdy(32'h12345678);
        check("dl no capture", 128'(dat(2)), 128'(0));
        check("dl ok2", 128'(ch_ok), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dl hold req", 128'(sdram_req), 128'(0));
        end
        downloading = 1'b0;
        @(negedge clk);
        check("dl rearm req",  128'(sdram_req),  128'(1));
        check("dl rearm addr", 128'(sdram_addr), 128'(22'h500));
        serve("dl after2", 22'h500, 1'b0, '0, 0, 0, 32'h22222222);
        serve("dl after0", 22'h050, 1'b0, '0, 0, 0, 32'h33333333);
        check("dl final ok", 128'(ch_ok), 128'(4'b0101));

        // ---- stale fill on channel 3
        do_reset();
        ch_cs = 4'b1000;
        set_addr(3, 22'h00100);
        wait_req("stale", 22'h00100);
        pulse_ack();
        set_addr(3, 22'h00200);
        pulse_rdy(32'hCAFE0003);
        check("stale ok",   128'(ch_ok[3]), 128'(0));
        check("stale data", 128'(dat(3)),   128'(32'hCAFE0003));
        serve("stale refill", 22'h00200, 1'b0, '0, 0, 0, 32'hCAFE0004);
        check("refill ok",   128'(ch_ok[3]), 128'(1));
        check("refill data", 128'(dat(3)),   128'(32'hCAFE0004));

        // ---- loop_rst blocks grants
        do_reset();
        loop_rst = 1'b1;
        ch_cs = 4'b0011;
        set_addr(0, 22'h600); set_addr(1, 22'h700);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("loop_rst req", 128'(sdram_req), 128'(0));
        end
        loop_rst = 1'b0;
        @(negedge clk);
        check("loop_rst release req",  128'(sdram_req),  128'(1));
        check("loop_rst release addr", 128'(sdram_addr), 128'(22'h600));
        serve("lr0", 22'h600, 1'b0, '0, 0, 0, 32'h66666666);
        serve("lr1", 22'h700, 1'b0, '0, 0, 0, 32'h77777777);

        // ---- hit table against four known cache lines
        do_reset();
        ch_addr = all_tags;
        ch_cs = 4'hF;
        for (int c = 0; c < N; c++)
            serve("tbl fill", ch_addr[c*AW +: AW], 1'b0, '0, 0, 0, 32'hC0DE0000 + 32'(c));
        loop_rst = 1'b1;
        for (int v = 0; v < 9; v++) begin
            ch_cs   = vecs[v].cs;
            ch_addr = vecs[v].addr;
            #1;
            check($sformatf("tbl ok v%0d", v), 128'(ch_ok), 128'(vecs[v].ok));
            @(negedge clk);
            check($sformatf("tbl req v%0d", v), 128'(sdram_req), 128'(0));
        end
        exp_data = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
        check("tbl data", 128'(ch_data), 128'(exp_data));

        // ---- randomized run against the transaction model
        do_reset();
        model_reset();
        for (int c = 0; c < N; c++) set_addr(c, 22'(c * 16));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 3) == 0) set_addr(c, 22'(c * 16 + int'($urandom_range(0, 3))));
                ch_cs[c] = ($urandom_range(0, 3) != 0);
            end
            downloading = ($urandom_range(0, 39) == 0);
            loop_rst    = ($urandom_range(0, 7) == 0);
            sdram_ack   = ($urandom_range(0, 2) == 0);
            data_rdy    = ($urandom_range(0, 2) == 0);
            data_read   = $urandom;
            model_edge();
            @(negedge clk);
            check("rnd ok", 128'(ch_ok), 128'(m_hit()));
            check("rnd data", 128'(ch_data), 128'({m_data[3], m_data[2], m_data[1], m_data[0]}));
            check("rnd req", 128'(sdram_req), 128'((q_out.size() != 0) && !q_out[0].acked));
            check("rnd addr", 128'(sdram_addr), 128'(m_addr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Parametrised N-channel arbiter between game-side ROM readers and the single framework SDRAM port (`sdram_addr`/`sdram_req`/`sdram_ack`/`data_read`/`data_rdy`).
- Each channel has a one-entry tagged cache, so a repeated address returns data immediately without an SDRAM access.
- Instantiated inside the game module between the game's ROM readers and the framework SDRAM port; it replaces the per-game hand-written ROM muxes.
- Arbitration is fixed-priority or round-robin, selected at build time.

Parameters:
- CHANNELS, 4, number of ROM reader channels (2..8).
- AW, 22, SDRAM word address width.
- DW, 32, data width of `data_read` and of each channel.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (channel 0 highest).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- downloading, input, 1: ROM download in progress; blocks requests and flushes the cache.
- loop_rst, input, 1: SDRAM init loop active; no requests may be issued.
- ch_cs, input, CHANNELS: per-channel read request, held while data is wanted.
- ch_addr, input, CHANNELS*AW: packed per-channel addresses; channel i is [i*AW +: AW].
- ch_ok, output, CHANNELS: ch_data[i] is valid for the current ch_addr[i].
- ch_data, output, CHANNELS*DW: packed per-channel cached data.
- sdram_addr, output, AW: address of the outstanding request.
- sdram_req, output, 1: request, held until ack.
- sdram_ack, input, 1: one-cycle pulse; request accepted.
- data_read, input, DW: SDRAM read data.
- data_rdy, input, 1: one-cycle pulse; data_read is valid.

Behaviour:
- **Reset:** on rst, all cache valid bits are 0, the FSM goes to IDLE, `sdram_req`=0, `sdram_addr`=0, `ch_data`=0, and the round-robin pointer is CHANNELS-1. Consequently `ch_ok`=0.
- **Hit:** hit[i] = ch_cs[i] & valid[i] & (tag[i]==ch_addr[i]). It is combinational from the registered tag and the live address.
- **ch_ok:** ch_ok[i] = hit[i]. When ch_cs[i]=0, ch_ok[i]=0.
- **Pending:** pending[i] = ch_cs[i] & ~hit[i].
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE:** if any pending bit is set and downloading=0 and loop_rst=0, grant one channel. The grant latches the channel index and `sdram_addr`<=ch_addr[g]. `sdram_req`<=1 and the FSM moves to REQ on the next edge.
- **REQ:** `sdram_req` stays 1 until the cycle sdram_ack=1. On that edge `sdram_req`<=0 and the FSM moves to WAIT.
- **WAIT:** on data_rdy=1, latch data_read into ch_data[g], the latched address into tag[g], set valid[g]=1, and return to IDLE. Also update the round-robin pointer to g.
- **Latency:**
  - Hit: 0 cycles (same cycle as ch_cs/ch_addr).
  - Miss with immediate ack: ch_ok rises 2 cycles after data_rdy's preceding ack, i.e. grant edge + ack edge + rdy edge. ch_ok is high the cycle after the data_rdy edge.
- **Round-robin:** grant the first pending channel strictly after the pointer, wrapping modulo CHANNELS. With a single pending channel, that channel wins even if it equals the pointer.
- **Fixed priority:** grant the lowest-index pending channel.
- **Address change during REQ/WAIT:** the request is not aborted. The cache is filled with the old address as tag, so ch_ok[g] stays 0 on tag mismatch. The channel re-arbitrates from IDLE.
- **ch_cs drop during REQ/WAIT:** the fill still completes.
- **Simultaneous events:** a fill of channel g and a new hit on another channel in the same cycle are independent. A grant is issued only from IDLE, so there is one outstanding request at most.
- **downloading=1:** takes effect on the next edge from any state. The FSM goes to IDLE, `sdram_req`=0, all valid bits are cleared, and data_rdy is ignored until the FSM is re-armed.
- **loop_rst=1:** blocks new grants only. An in-flight WAIT completes normally.
- **Ack/rdy outside their state:** sdram_ack outside REQ and data_rdy outside WAIT are ignored.

Decomposition:
- Package jtframe_rom_pkg holds:
  - the FSM state enum (IDLE/REQ/WAIT);
  - the RR mode constants;
  - a function for the clog2 index width.
- One sub-module, jtframe_rr_pick: a combinational rotating priority picker with inputs pending and pointer, and outputs grant index and any. In RR=0 mode the pointer is tied to CHANNELS-1.

Test Plan (CHANNELS=4, AW=22, DW=32):
- **Reset:** assert rst 3 cycles with ch_cs=4'hF -> ch_ok=0, sdram_req=0, sdram_addr=0 during reset and the cycle after.
- **Miss then hit:** ch_cs[1]=1, ch_addr[1]=22'h01234. Ack 2 cycles after req, data_rdy with 32'hDEADBEEF 3 cycles later -> sdram_addr=22'h01234, ch_data[1]=32'hDEADBEEF with ch_ok[1]=1. Change ch_addr[1] to 22'h01235 -> ch_ok[1]=0 the same cycle and a new request is issued.
- **Round-robin:** all four channels missing simultaneously, RR=1, pointer=3 after reset -> grant order 0,1,2,3. Then channel 0 re-missing together with channel 2 -> grant 2 before 0 only if the pointer is 1 (check against the pointer value). With RR=0, the order is always 0 first.
- **downloading in WAIT:** assert downloading in WAIT for channel 2, then pulse data_rdy -> the data is not captured, all ch_ok=0, and sdram_req stays 0 until downloading drops.
- **Stale fill:** change ch_addr[3] from 22'h00100 to 22'h00200 during WAIT -> after data_rdy, ch_ok[3]=0 and a second request goes out with sdram_addr=22'h00200.
- **loop_rst:** hold loop_rst=1 with pending channels -> sdram_req stays 0. Release -> the request is issued on the next edge.
